// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command sequencer.
// Word bit positions, command bundle, FSM states, clear/home range.
package lcd_pkg;

  localparam int ON_BIT   = 31;
  localparam int TOG_BIT  = 10;
  localparam int RS_BIT   = 9;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [7:0] CLR_LO = 8'h01;
  localparam logic [7:0] CLR_HI = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_PWRON,
    S_INIT
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  function automatic logic is_clear(cmd_t c);
    return !c.rs && (c.data >= CLR_LO) && (c.data <= CLR_HI);
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic cmd_t init_cmd(logic [1:0] i);
    cmd_t c;
    c.rs = 1'b0;
    case (i)
      2'd0:    c.data = 8'h38;
      2'd1:    c.data = 8'h0C;
      2'd2:    c.data = 8'h01;
      default: c.data = 8'h06;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; a push on full is taken only
// when a pop frees a slot in the same cycle.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  cmd_t                     i_din,
  input  logic                     i_pop,
  output cmd_t                     o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          wr;
  logic          rd;

  assign o_full  = level == (AW+1)'(DEPTH);
  assign o_empty = level == '0;
  assign rd      = i_pop && !o_empty;
  assign wr      = i_push && (!o_full || rd);
  assign o_dout  = mem[rd_ptr];
  assign o_level = level;

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues LCD register writes and replays them as timed HD44780 bus cycles.
// Define LCD_INIT_SEQ_EN for the automatic power-on init sequence.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int T_SETUP_CYC   = 2,
  parameter int T_PULSE_CYC   = 12,
  parameter int T_HOLD_CYC    = 1,
  parameter int T_EXEC_CYC    = 2000,
  parameter int T_CLEAR_CYC   = 82000,
  parameter int T_POWERON_CYC = 750000
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [31:0]                   i_lcd_word,
  input  logic                          i_ovf_clr,
  output logic                          o_lcd_on,
  output logic                          o_lcd_en,
  output logic                          o_lcd_rs,
  output logic                          o_lcd_rw,
  output logic [7:0]                    o_lcd_data,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int T_BASE = max_int(
    max_int(max_int(T_SETUP_CYC, T_PULSE_CYC), T_HOLD_CYC),
    max_int(T_EXEC_CYC, T_CLEAR_CYC));
`ifdef LCD_INIT_SEQ_EN
  localparam int T_MAX = max_int(T_BASE, T_POWERON_CYC);
`else
  localparam int T_MAX = T_BASE;
  localparam int UNUSED_T_PWR = T_POWERON_CYC;
`endif
  localparam int CW = $clog2(T_MAX + 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  cmd_t            cmd_q;
  cmd_t            cmd_nxt;
  cmd_t            fifo_dout;
  cmd_t            push_cmd;
  logic [TOG_BIT:0] prev;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  logic            on_q;
  logic            ovf_q;
  logic            unused_word;
`ifdef LCD_INIT_SEQ_EN
  logic [2:0]      init_idx;
  logic [2:0]      init_idx_nxt;
`endif

  assign unused_word   = ^i_lcd_word[ON_BIT-1:TOG_BIT+1];
  assign push          = i_lcd_word[TOG_BIT:0] != prev;
  assign push_cmd.rs   = i_lcd_word[RS_BIT];
  assign push_cmd.data = i_lcd_word[DATA_MSB:DATA_LSB];
  assign drop          = push && full && !pop;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_din   (push_cmd),
    .i_pop   (pop),
    .o_dout  (fifo_dout),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_fifo_level)
  );

  // prev tracks the word every cycle, so a dropped command is not retried
  always_ff @(posedge i_clk) begin
    prev <= i_lcd_word[TOG_BIT:0];
    if (i_reset) begin
      on_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      on_q <= i_lcd_word[ON_BIT];
      if (drop)           ovf_q <= 1'b1;
      else if (i_ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cmd_q <= '0;
`ifdef LCD_INIT_SEQ_EN
      state    <= S_PWRON;
      cnt      <= CW'(T_POWERON_CYC - 1);
      init_idx <= '0;
`else
      state <= S_IDLE;
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cmd_q <= cmd_nxt;
`ifdef LCD_INIT_SEQ_EN
      init_idx <= init_idx_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : '0;
    cmd_nxt   = cmd_q;
    pop       = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_idx_nxt = init_idx;
`endif
    unique case (state)
      S_IDLE: if (!empty) begin
        pop       = 1'b1;
        cmd_nxt   = fifo_dout;
        state_nxt = S_SETUP;
        cnt_nxt   = CW'(T_SETUP_CYC - 1);
      end
      S_SETUP: if (cnt == '0) begin
        state_nxt = S_PULSE;
        cnt_nxt   = CW'(T_PULSE_CYC - 1);
      end
      S_PULSE: if (cnt == '0) begin
        state_nxt = S_HOLD;
        cnt_nxt   = CW'(T_HOLD_CYC - 1);
      end
      S_HOLD: if (cnt == '0) begin
        state_nxt = S_WAIT;
        cnt_nxt   = is_clear(cmd_q) ? CW'(T_CLEAR_CYC - 1)
                                    : CW'(T_EXEC_CYC - 1);
      end
`ifdef LCD_INIT_SEQ_EN
      S_WAIT: if (cnt == '0) begin
        state_nxt = (init_idx == 3'd4) ? S_IDLE : S_INIT;
      end
      S_PWRON: if (cnt == '0) state_nxt = S_INIT;
      S_INIT: begin
        cmd_nxt      = init_cmd(init_idx[1:0]);
        init_idx_nxt = init_idx + 3'd1;
        state_nxt    = S_SETUP;
        cnt_nxt      = CW'(T_SETUP_CYC - 1);
      end
`else
      S_WAIT: if (cnt == '0) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_lcd_on   = on_q;
    o_lcd_en   = state == S_PULSE;
    o_lcd_rs   = cmd_q.rs;
    o_lcd_rw   = 1'b0;
    o_lcd_data = cmd_q.data;
    o_busy     = (state != S_IDLE) || !empty;
    o_overflow = ovf_q;
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with shortened LCD timings.
// Honours LCD_INIT_SEQ_EN by checking the init burst after each reset.
module tb_lcd_cmd_sequencer;

`ifdef LCD_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word = 32'h0;
  logic        ovf_clr = 1'b0;
  logic        lcd_on;
  logic        en;
  logic        rs;
  logic        rw;
  logic [7:0]  data;
  logic        busy;
  logic [2:0]  level;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hi_cnt = 0;
  logic en_d = 1'b0;
  int rise_t[$];
  int rise_dat[$];
  int fall_dat[$];
  int width_q[$];

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(
    .FIFO_DEPTH    (4),
    .T_SETUP_CYC   (2),
    .T_PULSE_CYC   (12),
    .T_HOLD_CYC    (1),
    .T_EXEC_CYC    (20),
    .T_CLEAR_CYC   (50),
    .T_POWERON_CYC (30)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_lcd_word   (word),
    .i_ovf_clr    (ovf_clr),
    .o_lcd_on     (lcd_on),
    .o_lcd_en     (en),
    .o_lcd_rs     (rs),
    .o_lcd_rw     (rw),
    .o_lcd_data   (data),
    .o_busy       (busy),
    .o_fifo_level (level),
    .o_overflow   (ovf)
  );

  always @(negedge clk) begin
    if (en && !en_d) begin
      rise_t.push_back(cyc);
      rise_dat.push_back(int'({rs, data}));
      hi_cnt = 0;
    end
    if (en) hi_cnt++;
    if (!en && en_d) begin
      width_q.push_back(hi_cnt);
      fall_dat.push_back(int'({rs, data}));
    end
    en_d = en;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rise_t.delete();
    rise_dat.delete();
    fall_dat.delete();
    width_q.delete();
  endtask

  task automatic wait_init();
`ifdef LCD_INIT_SEQ_EN
    int n;
    int exp_init[4] = '{32'h038, 32'h00C, 32'h001, 32'h006};
    n = 0;
    while (busy && n < 3000) begin
      tick(1);
      n++;
    end
    chk("init_done", busy, 0);
    chk("init_cnt", rise_dat.size(), 4);
    for (int i = 0; i < 4; i++) chk("init_cmd", at(rise_dat, i), exp_init[i]);
`endif
    clear_log();
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!en && n < 100) begin
      tick(1);
      n++;
    end
    chk("en_seen", en, 1);
  endtask

  initial begin
    // 1: reset with a live word, release must not push it
    reset = 1'b1;
    word  = 32'h8000_0241;
    tick(3);
    chk("rst_en", en, 0);
    chk("rst_on", lcd_on, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, INIT_EN);
    reset = 1'b0;
    tick(1);
    chk("on_latency", lcd_on, 1);
    wait_init();
    tick(40);
    chk("rel_no_pulse", rise_t.size(), 0);
    chk("rel_level", level, 0);

    // 2: two back-to-back data writes
    clear_log();
    word = 32'h0000_0641;
    tick(1);
    chk("t2_level", level, 1);
    chk("t2_busy", busy, 1);
    word = 32'h0000_0642;
    tick(1);
    chk("t2_level2", level, 1);
    tick(80);
    chk("t2_rises", rise_t.size(), 2);
    chk("t2_w0", at(width_q, 0), 12);
    chk("t2_w1", at(width_q, 1), 12);
    chk("t2_d0", at(rise_dat, 0), 32'h141);
    chk("t2_h0", at(fall_dat, 0), 32'h141);
    chk("t2_d1", at(rise_dat, 1), 32'h142);
    chk("t2_gap", at(rise_t, 1) - at(rise_t, 0), 36);
    chk("t2_busy_end", busy, 0);
    chk("t2_data_out", {rs, data}, 32'h142);
    chk("t2_on_off", lcd_on, 0);

    // 3: clear/home wait boundaries
    clear_log();
    word = 32'h0000_0003;
    tick(1);
    word = 32'h0000_0404;
    tick(1);
    word = 32'h0000_0201;
    tick(1);
    word = 32'h0000_0602;
    tick(200);
    chk("t3_rises", rise_t.size(), 4);
    chk("t3_gap_clr", at(rise_t, 1) - at(rise_t, 0), 66);
    chk("t3_gap_04", at(rise_t, 2) - at(rise_t, 1), 36);
    chk("t3_gap_rs1", at(rise_t, 3) - at(rise_t, 2), 36);
    chk("t3_d0", at(rise_dat, 0), 32'h003);
    chk("t3_d1", at(rise_dat, 1), 32'h004);
    chk("t3_d2", at(rise_dat, 2), 32'h101);
    chk("t3_d3", at(rise_dat, 3), 32'h102);

    // 4: six writes into a depth-4 queue
    clear_log();
    for (int i = 0; i < 6; i++) begin
      word = 32'h0000_0211 + i;
      tick(1);
    end
    chk("t4_level", level, 4);
    chk("t4_ovf", ovf, 1);
    tick(10);
    chk("t4_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", ovf, 0);
    tick(220);
    chk("t4_rises", rise_t.size(), 5);
    for (int i = 0; i < 5; i++) chk("t4_dat", at(rise_dat, i), 32'h111 + i);
    chk("t4_level_end", level, 0);
    chk("t4_busy_end", busy, 0);

    // 5: repeat write vs toggled write, ON bit alone
    clear_log();
    word = 32'h0000_0216;
    tick(50);
    chk("t5_same", rise_t.size(), 0);
    word = 32'h8000_0216;
    tick(2);
    chk("t5_on", lcd_on, 1);
    chk("t5_on_level", level, 0);
    tick(50);
    chk("t5_on_nopulse", rise_t.size(), 0);
    word = 32'h8000_0616;
    tick(50);
    chk("t5_tog", rise_t.size(), 1);
    chk("t5_dat", at(rise_dat, 0), 32'h116);

    // 6: reset in the middle of a pulse with a command queued
    clear_log();
    word = 32'h8000_0255;
    tick(1);
    word = 32'h8000_0256;
    tick(1);
    wait_en();
    tick(3);
    chk("t6_in_pulse", en, 1);
    chk("t6_queued", level, 1);
    reset = 1'b1;
    tick(1);
    chk("t6_en_drop", en, 0);
    chk("t6_level", level, 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    wait_init();
    tick(60);
    chk("t6_no_pulse", rise_t.size(), 0);
    chk("t6_level_end", level, 0);
    chk("t6_data", data, INIT_EN ? 32'h06 : 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
